// File: rtl/ads869x_cfg_sequencer_if.sv
// Frame handshake between the ADS869x config sequencer (master) and the SPI engine (slave).
// Outbound 32-bit command frames on valid/ready; inbound SDO word with a completion pulse.
interface ads869x_cfg_sequencer_if;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [31:0] rx_data;
    logic        rx_valid;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/ads869x_cfg_sequencer.sv
// Walks the ADS869x register table, issuing write (and optional read/NOP verify) SPI frames.
// First frame two cycles after start; frames held until frame_ready, one frame outstanding at a time.
module ads869x_cfg_sequencer #(
    parameter int N_ENTRIES = 2,
    parameter bit VERIFY    = 1'b1,
    parameter int RETRY_MAX = 3
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic                           i_start,
    input  logic [3:0]                     i_range_sel,
    input  logic                           i_int_ref_dis,
    input  logic [2:0]                     i_test_pattern,
    ads869x_cfg_sequencer_if.master        if_spi,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error,
    output logic [1:0]                     o_entry_idx
);

    localparam logic [6:0] CMD_WRITE = 7'b1101000;
    localparam logic [6:0] CMD_READ  = 7'b1100100;
    localparam logic [1:0] LAST_IDX  = 2'(N_ENTRIES - 1);
    localparam logic [2:0] RETRY_LIM = 3'(RETRY_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR_SEND, S_WR_WAIT, S_RD_SEND, S_RD_WAIT,
        S_NOP_SEND, S_NOP_WAIT, S_CHECK, S_NEXT, S_FINISH
    } state_t;

    state_t      r_state;
    logic [1:0]  r_entry_idx;
    logic [2:0]  r_retry_cnt;
    logic [3:0]  r_range_sel;
    logic        r_int_ref_dis;
    logic [2:0]  r_test_pattern;
    logic [31:0] r_frame_data;
    logic        r_frame_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_rd_val;

    logic [8:0]  w_addr;
    logic [15:0] w_data;
    logic        w_unused_rx_lo;

    // Readback only carries the register value in the upper half of the SDO word.
    assign w_unused_rx_lo = ^if_spi.rx_data[15:0];

    always_comb begin
        w_addr = 9'h014;
        w_data = {9'd0, r_int_ref_dis, 2'b00, r_range_sel};
        case (r_entry_idx)
            2'd1: begin
                w_addr = 9'h010;
                w_data = {13'd0, r_test_pattern};
            end
            2'd2: begin
                w_addr = 9'h00C;
                w_data = 16'h0000;
            end
            2'd3: begin
                w_addr = 9'h008;
                w_data = 16'h0000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_entry_idx    <= 2'd0;
            r_retry_cnt    <= 3'd0;
            r_range_sel    <= 4'd0;
            r_int_ref_dis  <= 1'b0;
            r_test_pattern <= 3'd0;
            r_frame_data   <= 32'h0;
            r_frame_valid  <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_rd_val       <= 16'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_range_sel    <= i_range_sel;
                        r_int_ref_dis  <= i_int_ref_dis;
                        r_test_pattern <= i_test_pattern;
                        r_error        <= 1'b0;
                        r_busy         <= 1'b1;
                        r_entry_idx    <= 2'd0;
                        r_retry_cnt    <= 3'd0;
                        r_state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_frame_data  <= {CMD_WRITE, w_addr, w_data};
                    r_frame_valid <= 1'b1;
                    r_state       <= S_WR_SEND;
                end
                S_WR_SEND: begin
                    if (if_spi.frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (if_spi.rx_valid) begin
                        if (VERIFY) begin
                            r_frame_data  <= {CMD_READ, w_addr, 16'h0000};
                            r_frame_valid <= 1'b1;
                            r_state       <= S_RD_SEND;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_RD_SEND: begin
                    if (if_spi.frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // The read result is shifted out during the following frame.
                    if (if_spi.rx_valid) begin
                        r_frame_data  <= 32'h0;
                        r_frame_valid <= 1'b1;
                        r_state       <= S_NOP_SEND;
                    end
                end
                S_NOP_SEND: begin
                    if (if_spi.frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= S_NOP_WAIT;
                    end
                end
                S_NOP_WAIT: begin
                    if (if_spi.rx_valid) begin
                        r_rd_val <= if_spi.rx_data[31:16];
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_rd_val == w_data) begin
                        r_state <= S_NEXT;
                    end else if (r_retry_cnt < RETRY_LIM) begin
                        r_retry_cnt <= r_retry_cnt + 3'd1;
                        r_state     <= S_LOAD;
                    end else begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_NEXT: begin
                    r_retry_cnt <= 3'd0;
                    if (r_entry_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_entry_idx <= r_entry_idx + 2'd1;
                        r_state     <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    r_busy      <= 1'b0;
                    r_entry_idx <= 2'd0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_spi.frame_data  = r_frame_data;
    assign if_spi.frame_valid = r_frame_valid;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_error            = r_error;
    assign o_entry_idx        = r_entry_idx;

endmodule
